nonce_dispatcher: RTL and testbench
===================================

Name: nonce_dispatcher

Overview:
- Schedules nonces across NCORES parallel scrypt hash cores that share one 80-byte header register.
- Hands each idle core the next nonce from a global counter and arbitrates simultaneous core completions round-robin.
- Stops all cores on the first hit and presents the winning nonce to the I2C transceiver via nonce_ready/found_nonce.
- Sits between main_controller (job_start/job_abort) and the core array.

Parameters:
- NCORES, 4, number of hash cores; 2..16.
- NONCE_W, 32, nonce width.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- job_start  in  1  1-cycle pulse: header loaded, begin job. Ignored unless IDLE.
- job_abort  in  1  1-cycle pulse: cancel job from any state.
- nonce_base  in  NONCE_W  first nonce; sampled on job_start.
- nonce_limit  in  NONCE_W  last nonce, inclusive; sampled on job_start.
- core_done  in  NCORES  per-core level. Held high from result until the core's next core_start or core_abort.
- core_hit  in  NCORES  per-core result. Valid only while the matching core_done bit is high.
- core_start  out  NCORES  1-cycle pulse to one core: start hashing core_nonce[i].
- core_nonce  out  NCORES*NONCE_W  per-core registered nonce. Stable from core_start until that core's next core_start.
- core_abort  out  1  1-cycle pulse to all cores: stop and return idle.
- nonce_ready  out  1  level: found_nonce valid. Held until report_ack.
- found_nonce  out  NONCE_W  winning nonce.
- report_ack  in  1  1-cycle pulse from I2C side: result consumed.
- exhausted  out  1  level: range done, no hit. Cleared on next job_start.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values:
  - all outputs 0; core_nonce all 0; found_nonce 0.
  - state IDLE; counter 0; rr pointer 0; per-core busy mask 0.
- Registers:
  - next_nonce counter: NONCE_W bits.
  - last_issued flag.
  - busy_mask: NCORES bits.
  - rr_ptr: clog2(NCORES) bits.
- States:
  - IDLE: on job_start, next_nonce=nonce_base, limit latched, exhausted=0, last_issued=0 -> FILL.
  - FILL:
    - Each cycle issues next_nonce to core f, f=0..NCORES-1 in order. Pulses core_start[f], sets busy_mask[f], increments next_nonce.
    - The first core_start occurs the cycle after job_start.
    - If the issued nonce equals limit, set last_issued and go to RUN without filling the remaining cores.
    - After core NCORES-1 -> RUN.
  - RUN, each cycle:
    - Form req = core_done & busy_mask.
    - Grant one index g by round-robin starting at rr_ptr. After a grant, rr_ptr = g+1 mod NCORES.
    - Hit priority: if any req bit with core_hit is set, grant the round-robin-first hitting core regardless of non-hit requests. Then found_nonce=core_nonce[g], core_abort pulse, busy_mask=0 -> REPORT.
    - Else, if a grant exists and !last_issued: reissue to g. core_nonce[g]=next_nonce, core_start[g] pulse in the same cycle, next_nonce++, and last_issued is set when next_nonce==limit.
    - Else, if a grant exists and last_issued: clear busy_mask[g].
    - Non-granted done cores keep core_done high and are served on later cycles. Throughput is 1 completion per cycle.
    - When busy_mask==0 and last_issued -> DONE_NOHIT.
  - REPORT: nonce_ready=1. On report_ack: nonce_ready=0 -> IDLE.
  - DONE_NOHIT: exhausted=1 -> IDLE the next cycle. exhausted stays high until job_start.
- Counter:
  - Unsigned, NONCE_W bits.
  - If limit < base, the range wraps through 2^NONCE_W-1 to 0. Termination is by equality only.
  - Full range (base=0, limit=all-ones) is legal; the counter never needs a carry-out.
- Simultaneous events:
  - job_abort has the highest priority in every state: core_abort pulse (unless already IDLE), busy_mask=0, nonce_ready=0, no exhausted, -> IDLE.
  - job_start in the same cycle as job_abort: the abort wins and the start is dropped.
  - report_ack outside REPORT: ignored.
  - core_done on a bit with busy_mask=0: ignored.
- Reset mid-operation: all state is cleared asynchronously. Cores are reset by the same n_rst; core_abort is not pulsed.

Decomposition:
- Shared package scrypt_pkg:
  - NONCE_W.
  - state enum dispatch_state_t {IDLE, FILL, RUN, REPORT, DONE_NOHIT}.
  - function clog2.
- Sub-module rr_arbiter (NCORES-wide request, rotating pointer input, one-hot grant plus index, valid). Instantiated twice:
  - once on the hit-qualified requests;
  - once on all requests, selecting the hit grant when valid.

Test Plan (NCORES=4):
- Basic fill:
  - Stimulus: base=0x100, limit=0x1FF, job_start.
  - Required: core_start 0001,0010,0100,1000 on cycles 1-4; core_nonce = 0x100..0x103; busy=1.
- Reissue and round-robin:
  - Stimulus: done on cores 1 and 3 in the same cycle, no hit, rr_ptr=2.
  - Required: core 3 gets 0x104 first; core 1 gets 0x105 one cycle later.
- Hit priority:
  - Stimulus: cores 0 (no hit) and 2 (hit, nonce 0x102) done together.
  - Required: found_nonce=0x102, core_abort 1 cycle, nonce_ready high until report_ack, then IDLE.
- Exhaustion:
  - Stimulus: base=0xFFFFFFFE, limit=0x00000001; all cores return no hit.
  - Required: exactly four nonces issued (FFFFFFFE, FFFFFFFF, 0, 1); exhausted=1 once all cores are done; busy drops.
- Short range:
  - Stimulus: base=limit=0x55.
  - Required: only core 0 started, then RUN; exhausted after its done.
- Abort:
  - Stimulus: job_abort in RUN with 3 cores busy, plus job_start in the same cycle.
  - Required: core_abort pulse, IDLE, no nonce_ready or exhausted, start ignored. A later job_start works normally.

Source files
------------

// File: rtl/scrypt_pkg.sv
// Shared types and constants for the scrypt nonce dispatch logic.
package scrypt_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    REPORT,
    DONE_NOHIT
  } dispatch_state_t;

  // Ceiling log2, never less than 1 so index vectors always have a bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/nonce_dispatcher_if.sv
// Bus between the nonce dispatcher (master) and the hash core array (slave).
interface nonce_dispatcher_if #(
  parameter int NCORES  = 4,
  parameter int NONCE_W = 32
);

  logic [NCORES-1:0]         core_start;
  logic [NCORES*NONCE_W-1:0] core_nonce;
  logic                      core_abort;
  logic [NCORES-1:0]         core_done;
  logic [NCORES-1:0]         core_hit;

  modport master (
    output core_start, core_nonce, core_abort,
    input  core_done, core_hit
  );

  modport slave (
    input  core_start, core_nonce, core_abort,
    output core_done, core_hit
  );

endinterface

// File: rtl/nonce_dispatcher_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping around.
module rr_arbiter
  import scrypt_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan the requests starting at ptr and keep the first one found.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        idx      = IDX_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Hands nonces from a global counter to idle hash cores, serves completions
// round-robin with hits first, and reports the first winning nonce.
module nonce_dispatcher #(
  parameter int NCORES  = 4,
  parameter int NONCE_W = scrypt_pkg::NONCE_W
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 job_start,
  input  logic                 job_abort,
  input  logic [NONCE_W-1:0]   nonce_base,
  input  logic [NONCE_W-1:0]   nonce_limit,
  input  logic                 report_ack,
  nonce_dispatcher_if.master   core_bus,
  output logic                 nonce_ready,
  output logic [NONCE_W-1:0]   found_nonce,
  output logic                 exhausted,
  output logic                 busy
);

  import scrypt_pkg::*;

  localparam int IDX_W = clog2(NCORES);

  dispatch_state_t                  state_q, state_d;
  logic [NONCE_W-1:0]               next_nonce_q, next_nonce_d;
  logic [NONCE_W-1:0]               limit_q, limit_d;
  logic                             last_issued_q, last_issued_d;
  logic [NCORES-1:0]                busy_mask_q, busy_mask_d;
  logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                 fill_idx_q, fill_idx_d;
  logic [NCORES-1:0][NONCE_W-1:0]   core_nonce_q, core_nonce_d;
  logic [NCORES-1:0]                core_start_q, core_start_d;
  logic                             core_abort_q, core_abort_d;
  logic [NONCE_W-1:0]               found_nonce_q, found_nonce_d;
  logic                             nonce_ready_q, nonce_ready_d;
  logic                             exhausted_q, exhausted_d;

  logic [NCORES-1:0] req_all, req_hit;
  logic [NCORES-1:0] all_grant, hit_grant;
  logic [IDX_W-1:0]  all_idx, hit_idx;
  logic              all_valid, hit_valid;

  // A core whose start is still on the wire shows its stale done level, so mask it.
  assign req_all = core_bus.core_done & busy_mask_q & ~core_start_q;
  assign req_hit = req_all & core_bus.core_hit;

  rr_arbiter #(.N(NCORES), .IDX_W(IDX_W)) u_arb_hit (
    .req   (req_hit),
    .ptr   (rr_ptr_q),
    .grant (hit_grant),
    .idx   (hit_idx),
    .valid (hit_valid)
  );

  rr_arbiter #(.N(NCORES), .IDX_W(IDX_W)) u_arb_all (
    .req   (req_all),
    .ptr   (rr_ptr_q),
    .grant (all_grant),
    .idx   (all_idx),
    .valid (all_valid)
  );

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (int'(p) == NCORES - 1) ? '0 : p + 1'b1;
  endfunction

  // Next-state logic: job start/fill, completion service, report and abort.
  always_comb begin
    state_d       = state_q;
    next_nonce_d  = next_nonce_q;
    limit_d       = limit_q;
    last_issued_d = last_issued_q;
    busy_mask_d   = busy_mask_q;
    rr_ptr_d      = rr_ptr_q;
    fill_idx_d    = fill_idx_q;
    core_nonce_d  = core_nonce_q;
    core_start_d  = '0;
    core_abort_d  = 1'b0;
    found_nonce_d = found_nonce_q;
    nonce_ready_d = nonce_ready_q;
    exhausted_d   = exhausted_q;

    case (state_q)
      IDLE: begin
        // Core 0 is issued straight from the start pulse so its start lands one cycle later.
        if (job_start && !job_abort) begin
          limit_d         = nonce_limit;
          exhausted_d     = 1'b0;
          core_nonce_d[0] = nonce_base;
          core_start_d[0] = 1'b1;
          busy_mask_d     = '0;
          busy_mask_d[0]  = 1'b1;
          next_nonce_d    = nonce_base + 1'b1;
          last_issued_d   = (nonce_base == nonce_limit);
          fill_idx_d      = IDX_W'(1);
          state_d         = (nonce_base == nonce_limit) ? RUN : FILL;
        end
      end
      FILL: begin
        core_nonce_d[fill_idx_q] = next_nonce_q;
        core_start_d[fill_idx_q] = 1'b1;
        busy_mask_d[fill_idx_q]  = 1'b1;
        next_nonce_d             = next_nonce_q + 1'b1;
        fill_idx_d               = fill_idx_q + 1'b1;
        if (next_nonce_q == limit_q) begin
          last_issued_d = 1'b1;
          state_d       = RUN;
        end else if (int'(fill_idx_q) == NCORES - 1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (hit_valid) begin
          for (int i = 0; i < NCORES; i++) begin
            if (hit_grant[i]) found_nonce_d = core_nonce_q[i];
          end
          rr_ptr_d      = next_ptr(hit_idx);
          core_abort_d  = 1'b1;
          busy_mask_d   = '0;
          nonce_ready_d = 1'b1;
          state_d       = REPORT;
        end else if (all_valid) begin
          rr_ptr_d = next_ptr(all_idx);
          if (!last_issued_q) begin
            core_nonce_d[all_idx] = next_nonce_q;
            core_start_d[all_idx] = 1'b1;
            next_nonce_d          = next_nonce_q + 1'b1;
            last_issued_d         = (next_nonce_q == limit_q);
          end else begin
            busy_mask_d = busy_mask_q & ~all_grant;
          end
        end else if (busy_mask_q == '0 && last_issued_q) begin
          state_d = DONE_NOHIT;
        end
      end
      REPORT: begin
        if (report_ack) begin
          nonce_ready_d = 1'b0;
          state_d       = IDLE;
        end
      end
      DONE_NOHIT: begin
        exhausted_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything decided above and leaves issued nonces untouched.
    if (job_abort) begin
      core_abort_d  = (state_q != IDLE);
      core_start_d  = '0;
      core_nonce_d  = core_nonce_q;
      found_nonce_d = found_nonce_q;
      busy_mask_d   = '0;
      nonce_ready_d = 1'b0;
      exhausted_d   = exhausted_q;
      state_d       = IDLE;
    end
  end

  // State registers, cleared asynchronously together with the cores.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      next_nonce_q  <= '0;
      limit_q       <= '0;
      last_issued_q <= 1'b0;
      busy_mask_q   <= '0;
      rr_ptr_q      <= '0;
      fill_idx_q    <= '0;
      core_nonce_q  <= '0;
      core_start_q  <= '0;
      core_abort_q  <= 1'b0;
      found_nonce_q <= '0;
      nonce_ready_q <= 1'b0;
      exhausted_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_nonce_q  <= next_nonce_d;
      limit_q       <= limit_d;
      last_issued_q <= last_issued_d;
      busy_mask_q   <= busy_mask_d;
      rr_ptr_q      <= rr_ptr_d;
      fill_idx_q    <= fill_idx_d;
      core_nonce_q  <= core_nonce_d;
      core_start_q  <= core_start_d;
      core_abort_q  <= core_abort_d;
      found_nonce_q <= found_nonce_d;
      nonce_ready_q <= nonce_ready_d;
      exhausted_q   <= exhausted_d;
    end
  end

  assign core_bus.core_start = core_start_q;
  assign core_bus.core_nonce = core_nonce_q;
  assign core_bus.core_abort = core_abort_q;
  assign nonce_ready         = nonce_ready_q;
  assign found_nonce         = found_nonce_q;
  assign exhausted           = exhausted_q;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed bench for nonce_dispatcher with a start scoreboard and a simple core model.
module tb_nonce_dispatcher;

  localparam int NCORES = 4;
  localparam int NW     = 32;

  typedef struct {
    int          core;
    logic [31:0] nonce;
  } start_t;

  logic          clk;
  logic          n_rst;
  logic          job_start;
  logic          job_abort;
  logic          report_ack;
  logic [NW-1:0] nonce_base;
  logic [NW-1:0] nonce_limit;
  logic          nonce_ready;
  logic [NW-1:0] found_nonce;
  logic          exhausted;
  logic          busy;

  nonce_dispatcher_if #(.NCORES(NCORES), .NONCE_W(NW)) core_bus ();

  nonce_dispatcher #(.NCORES(NCORES), .NONCE_W(NW)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .job_start   (job_start),
    .job_abort   (job_abort),
    .nonce_base  (nonce_base),
    .nonce_limit (nonce_limit),
    .report_ack  (report_ack),
    .core_bus    (core_bus),
    .nonce_ready (nonce_ready),
    .found_nonce (found_nonce),
    .exhausted   (exhausted),
    .busy        (busy)
  );

  start_t sb[$];
  int     tests_run    = 0;
  int     tests_failed = 0;
  int     start_count  = 0;
  int     starts_before;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic abort, input logic ack,
                               input logic [NW-1:0] base, input logic [NW-1:0] limit);
    job_start   = start;
    job_abort   = abort;
    report_ack  = ack;
    nonce_base  = base;
    nonce_limit = limit;
  endtask

  task automatic applyDone(input logic [NCORES-1:0] done_mask,
                           input logic [NCORES-1:0] hit_mask);
    core_bus.core_done = core_bus.core_done | done_mask;
    core_bus.core_hit  = (core_bus.core_hit & ~done_mask) | (hit_mask & done_mask);
  endtask

  task automatic expectStart(input int core, input logic [31:0] nonce);
    start_t s;
    s.core  = core;
    s.nonce = nonce;
    sb.push_back(s);
  endtask

  // Advance to the next falling edge, score any core starts, then update the core model.
  task automatic tick();
    start_t      exp_s;
    logic [31:0] got;
    @(negedge clk);
    for (int i = 0; i < NCORES; i++) begin
      if (core_bus.core_start[i]) begin
        start_count++;
        got = core_bus.core_nonce[i*NW +: NW];
        checkOutput("start_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_s = sb.pop_front();
          checkOutput("start_core", 64'(i), 64'(exp_s.core));
          checkOutput("start_nonce", 64'(got), 64'(exp_s.nonce));
        end
      end
    end
    for (int i = 0; i < NCORES; i++) begin
      if (core_bus.core_start[i] || core_bus.core_abort) begin
        core_bus.core_done[i] = 1'b0;
        core_bus.core_hit[i]  = 1'b0;
      end
    end
  endtask

  initial begin
    n_rst              = 1'b0;
    core_bus.core_done = '0;
    core_bus.core_hit  = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();

    // Reset state
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_nonce_ready", 64'(nonce_ready), 64'd0);
    checkOutput("reset_exhausted", 64'(exhausted), 64'd0);
    checkOutput("reset_found_nonce", 64'(found_nonce), 64'd0);
    checkOutput("reset_core_start", 64'(core_bus.core_start), 64'd0);
    checkOutput("reset_core_abort", 64'(core_bus.core_abort), 64'd0);
    checkOutput("reset_core_nonce_nonzero", 64'(core_bus.core_nonce != '0), 64'd0);
    n_rst = 1'b1;
    tick();

    // Basic fill: 0x100..0x1FF, one core started per cycle
    for (int f = 0; f < NCORES; f++) expectStart(f, 32'h100 + f);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h1FF);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h100, 32'h1FF);
    for (int f = 0; f < NCORES; f++) begin
      checkOutput("fill_core_start", 64'(core_bus.core_start), 64'(1 << f));
      checkOutput("fill_busy", 64'(busy), 64'd1);
      if (f < NCORES - 1) tick();
    end
    tick();
    checkOutput("fill_no_extra_start", 64'(core_bus.core_start), 64'd0);

    // Reissue: core 1 alone moves rr pointer to 2
    expectStart(1, 32'h104);
    applyDone(4'b0010, 4'b0000);
    tick();
    checkOutput("reissue_single", 64'(core_bus.core_start), 64'b0010);

    // Round-robin: cores 1 and 3 together with pointer at 2, core 3 first
    expectStart(3, 32'h105);
    expectStart(1, 32'h106);
    applyDone(4'b1010, 4'b0000);
    tick();
    checkOutput("rr_first_core3", 64'(core_bus.core_start), 64'b1000);
    tick();
    checkOutput("rr_second_core1", 64'(core_bus.core_start), 64'b0010);
    tick();

    // Hit priority: core 3 (no hit) would win round-robin, core 1 hits with 0x106
    applyDone(4'b1010, 4'b0010);
    tick();
    checkOutput("hit_core_abort", 64'(core_bus.core_abort), 64'd1);
    checkOutput("hit_nonce_ready", 64'(nonce_ready), 64'd1);
    checkOutput("hit_found_nonce", 64'(found_nonce), 64'h106);
    tick();
    checkOutput("hit_abort_single_cycle", 64'(core_bus.core_abort), 64'd0);
    tick();
    tick();
    checkOutput("hit_ready_held", 64'(nonce_ready), 64'd1);
    checkOutput("hit_busy_in_report", 64'(busy), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("ack_nonce_ready", 64'(nonce_ready), 64'd0);
    checkOutput("ack_idle", 64'(busy), 64'd0);

    // Exhaustion across the wrap: FFFFFFFE, FFFFFFFF, 0, 1
    starts_before = start_count;
    expectStart(0, 32'hFFFF_FFFE);
    expectStart(1, 32'hFFFF_FFFF);
    expectStart(2, 32'h0000_0000);
    expectStart(3, 32'h0000_0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    tick();
    applyDone(4'b1111, 4'b0000);
    for (int k = 0; k < 20 && !exhausted; k++) tick();
    checkOutput("wrap_exhausted", 64'(exhausted), 64'd1);
    checkOutput("wrap_busy_dropped", 64'(busy), 64'd0);
    checkOutput("wrap_start_count", 64'(start_count - starts_before), 64'd4);
    checkOutput("wrap_no_ready", 64'(nonce_ready), 64'd0);

    // Short range: single nonce 0x55, only core 0
    starts_before = start_count;
    expectStart(0, 32'h55);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h55, 32'h55);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("short_core0_start", 64'(core_bus.core_start), 64'b0001);
    checkOutput("short_exhausted_cleared", 64'(exhausted), 64'd0);
    tick();
    tick();
    checkOutput("short_no_fill", 64'(core_bus.core_start), 64'd0);
    checkOutput("short_busy", 64'(busy), 64'd1);
    applyDone(4'b0001, 4'b0000);
    for (int k = 0; k < 10 && !exhausted; k++) tick();
    checkOutput("short_exhausted", 64'(exhausted), 64'd1);
    checkOutput("short_start_count", 64'(start_count - starts_before), 64'd1);

    // Abort in RUN with three cores busy, start in the same cycle is dropped
    expectStart(0, 32'h200);
    expectStart(1, 32'h201);
    expectStart(2, 32'h202);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h200, 32'h202);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h900, 32'h9FF);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("abort_core_abort", 64'(core_bus.core_abort), 64'd1);
    checkOutput("abort_idle", 64'(busy), 64'd0);
    tick();
    tick();
    checkOutput("abort_stays_idle", 64'(busy), 64'd0);
    checkOutput("abort_no_ready", 64'(nonce_ready), 64'd0);
    checkOutput("abort_no_exhausted", 64'(exhausted), 64'd0);
    checkOutput("abort_pulse_ended", 64'(core_bus.core_abort), 64'd0);

    // A later job runs normally and finishes with a hit on core 3
    for (int f = 0; f < NCORES; f++) expectStart(f, 32'h300 + f);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h300, 32'h3FF);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    tick();
    checkOutput("restart_busy", 64'(busy), 64'd1);
    tick();
    applyDone(4'b1000, 4'b1000);
    for (int k = 0; k < 10 && !nonce_ready; k++) tick();
    checkOutput("restart_ready", 64'(nonce_ready), 64'd1);
    checkOutput("restart_found", 64'(found_nonce), 64'h303);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("restart_ack_idle", 64'(busy), 64'd0);

    tick();
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
